// File: rtl/cacheline_adapter_if.sv
// Bundle of the cache-side (dfp) line port and the memory-side (bmem) burst port.
// "slave" is the adapter's view; "master" is the cache plus memory environment.
interface cacheline_adapter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
);
    logic [31:0]           dfp_addr;
    logic                  dfp_read;
    logic                  dfp_write;
    logic [LINE_WIDTH-1:0] dfp_wdata;
    logic [LINE_WIDTH-1:0] dfp_rdata;
    logic                  dfp_resp;

    logic [31:0]           bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts whole-line cache reads/writes into 4-beat bursts on the bmem port.
// One request in flight; every request finishes with a single-cycle dfp_resp.
module cacheline_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_adapter_if.slave  bus
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [31:0]      OFFSET_MASK = 32'(LINE_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_WR,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

    logic [31:0]           bmem_addr_o;
    logic                  bmem_read_o;
    logic                  bmem_write_o;
    logic [BEAT_WIDTH-1:0] bmem_wdata_o;
    logic                  dfp_resp_o;

    logic [BEAT_WIDTH-1:0] beat_w [BEATS];

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign beat_w[gi] = line_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        line_d       = line_q;
        rdata_d      = rdata_q;
        bmem_addr_o  = '0;
        bmem_read_o  = 1'b0;
        bmem_write_o = 1'b0;
        bmem_wdata_o = '0;
        dfp_resp_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Read has priority when the cache raises both requests.
                if (bus.dfp_read) begin
                    addr_d  = bus.dfp_addr & ~OFFSET_MASK;
                    cnt_d   = '0;
                    state_d = S_RD_REQ;
                end else if (bus.dfp_write) begin
                    addr_d  = bus.dfp_addr & ~OFFSET_MASK;
                    line_d  = bus.dfp_wdata;
                    cnt_d   = '0;
                    state_d = S_WR;
                end
            end
            S_RD_REQ: begin
                bmem_read_o = 1'b1;
                bmem_addr_o = addr_q;
                if (bus.bmem_ready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (bus.bmem_rvalid) begin
                    line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = bus.bmem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = line_d;
                        state_d = S_RESP;
                    end
                end
            end
            S_WR: begin
                bmem_write_o = 1'b1;
                bmem_addr_o  = addr_q;
                bmem_wdata_o = beat_w[cnt_q];
                // Only the first beat waits for memory; the rest stream back-to-back.
                if (cnt_q != '0 || bus.bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = line_q;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                dfp_resp_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bmem_addr  = bmem_addr_o;
    assign bus.bmem_read  = bmem_read_o;
    assign bus.bmem_write = bmem_write_o;
    assign bus.bmem_wdata = bmem_wdata_o;
    assign bus.dfp_resp   = dfp_resp_o;
    assign bus.dfp_rdata  = rdata_q;
endmodule
